conv_window_sequencer: RTL and testbench

- Parametrised successor to the single-size conv enable generator.
- Tracks a raster-order pixel stream for one image frame and flags each pixel that completes a valid KERNEL_SIZE x KERNEL_SIZE window at the configured stride.
- Also reports output coordinates and frame-level start/busy/done status.
- Sits between the line-buffer/shift-register datapath and the MAC array, and gates the MAC accumulate/write.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/axis_stride_counter.sv | 80 ++++++++
 rtl/conv_window_sequencer.sv | 143 ++++++++++++++
 tb/tb_conv_window_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution window sequencer and the
// line-buffer datapath that feeds it.
//   state_t      frame sequencing states (IDLE/RUN/DONE)
//   clog2_min1   counter width for a value range, never narrower than 1 bit
//   out_dim      number of valid window positions along one image axis
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int out_dim(input int img, input int kernel, input int stride);
        return (img - kernel) / stride + 1;
    endfunction

endpackage

// File: rtl/axis_stride_counter.sv
// axis_stride_counter: one axis (column or row) of the window sequencer.
// Tracks the pixel position along the axis, a stride phase that is zero on
// every position where a window may end, and the output index of the next
// window along this axis.
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous zeroing of all counters
//   step       advance the position by one
//   adv        a window along this axis was flagged; advance the output index
//   wrap       step on the last position (combinational)
//   qual       current position may end a window (combinational)
//   idx        output index of the window ending at the current position
module axis_stride_counter
    import conv_pkg::*;
#(
    parameter  int SIZE        = 28,
    parameter  int KERNEL_SIZE = 5,
    parameter  int STRIDE      = 1,
    parameter  int OUT_N       = 24,
    localparam int PW          = clog2_min1(SIZE),
    localparam int SW          = clog2_min1(STRIDE),
    localparam int OW          = clog2_min1(OUT_N),
    localparam int IW          = OW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic          adv,
    output logic          wrap,
    output logic          qual,
    output logic [OW-1:0] idx
);

    logic [PW-1:0] pos;
    logic [SW-1:0] phase;
    // One spare bit so the index can reach OUT_N without wrapping back to 0.
    logic [IW-1:0] idx_full;

    assign wrap = step && (pos == PW'(SIZE - 1));
    assign qual = (pos >= PW'(KERNEL_SIZE - 1)) && (phase == SW'(0))
                  && (idx_full < IW'(OUT_N));
    assign idx  = idx_full[OW-1:0];

    // Position, stride phase and output index counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= PW'(0);
            phase    <= SW'(0);
            idx_full <= IW'(0);
        end else if (clear) begin
            pos      <= PW'(0);
            phase    <= SW'(0);
            idx_full <= IW'(0);
        end else begin
            if (step) begin
                if (wrap) begin
                    pos   <= PW'(0);
                    phase <= SW'(0);
                end else begin
                    pos <= pos + PW'(1);
                    // Phase is held at 0 until the first full window, so it
                    // reads 0 on position KERNEL_SIZE-1 and every STRIDE after.
                    if (pos < PW'(KERNEL_SIZE - 1)) begin
                        phase <= SW'(0);
                    end else if (phase == SW'(STRIDE - 1)) begin
                        phase <= SW'(0);
                    end else begin
                        phase <= phase + SW'(1);
                    end
                end
            end
            if (wrap) begin
                idx_full <= IW'(0);
            end else if (adv) begin
                idx_full <= idx_full + IW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: follows a raster-order pixel stream for one frame and
// flags every accepted pixel that completes a KERNEL_SIZE x KERNEL_SIZE window
// at the configured stride, gating the MAC array accumulate/write.
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a frame (sampled only in IDLE)
//   clear       synchronous abort back to IDLE, no frame_done
//   pix_valid   one pixel presented; always accepted in RUN
//   busy        high while in RUN
//   win_valid   window ending at the last accepted pixel is valid
//   out_col     output column of the flagged window
//   out_row     output row of the flagged window
//   frame_done  one-cycle pulse after the last pixel of the frame
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter  int IMG_W       = 28,
    parameter  int IMG_H       = 28,
    parameter  int KERNEL_SIZE = 5,
    parameter  int STRIDE      = 1,
    localparam int OUT_W       = out_dim(IMG_W, KERNEL_SIZE, STRIDE),
    localparam int OUT_H       = out_dim(IMG_H, KERNEL_SIZE, STRIDE),
    localparam int OCW         = clog2_min1(OUT_W),
    localparam int ORW         = clog2_min1(OUT_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           clear,
    input  logic           pix_valid,
    output logic           busy,
    output logic           win_valid,
    output logic [OCW-1:0] out_col,
    output logic [ORW-1:0] out_row,
    output logic           frame_done
);

    state_t         state;
    logic           accept;
    logic           hit;
    logic           col_wrap;
    logic           col_qual;
    logic           row_wrap;
    logic           row_qual;
    logic [OCW-1:0] col_idx;
    logic [ORW-1:0] row_idx;

    // A same-cycle clear drops the pixel.
    assign accept = pix_valid && (state == ST_RUN) && !clear;
    assign hit    = accept && col_qual && row_qual;

    axis_stride_counter #(
        .SIZE        (IMG_W),
        .KERNEL_SIZE (KERNEL_SIZE),
        .STRIDE      (STRIDE),
        .OUT_N       (OUT_W)
    ) u_col (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .step  (accept),
        .adv   (hit),
        .wrap  (col_wrap),
        .qual  (col_qual),
        .idx   (col_idx)
    );

    // The row axis steps once per completed input row; its output index moves
    // on after a qualifying row, i.e. after that row's last flagged window.
    axis_stride_counter #(
        .SIZE        (IMG_H),
        .KERNEL_SIZE (KERNEL_SIZE),
        .STRIDE      (STRIDE),
        .OUT_N       (OUT_H)
    ) u_row (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .step  (col_wrap),
        .adv   (col_wrap && row_qual),
        .wrap  (row_wrap),
        .qual  (row_qual),
        .idx   (row_idx)
    );

    // Frame state machine with registered status and window outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_col    <= OCW'(0);
            out_row    <= ORW'(0);
        end else if (clear) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    win_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    win_valid <= hit;
                    if (hit) begin
                        out_col <= col_idx;
                        out_row <= row_idx;
                    end
                    // row_wrap only fires on the accepted bottom-right pixel.
                    if (row_wrap) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        busy       <= 1'b1;
                        frame_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    win_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    win_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: three instances (28x28 K5 S1, 8x8 K3 S2,
// 5x5 K5 S1) checked every cycle against a pixel-index model, plus literal
// frame-level expectations.
module tb_conv_window_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] clear_v = 3'b000;
    logic [2:0] pix_v   = 3'b000;
    logic [2:0] busy_v;
    logic [2:0] win_v;
    logic [2:0] done_v;
    logic [4:0] a_oc, a_or;
    logic [1:0] b_oc, b_or;
    logic [0:0] c_oc, c_or;

    always #5 clk = ~clk;

    conv_window_sequencer #(.IMG_W(28), .IMG_H(28), .KERNEL_SIZE(5), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .clear(clear_v[0]), .pix_valid(pix_v[0]),
        .busy(busy_v[0]), .win_valid(win_v[0]), .out_col(a_oc), .out_row(a_or),
        .frame_done(done_v[0]));

    conv_window_sequencer #(.IMG_W(8), .IMG_H(8), .KERNEL_SIZE(3), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .clear(clear_v[1]), .pix_valid(pix_v[1]),
        .busy(busy_v[1]), .win_valid(win_v[1]), .out_col(b_oc), .out_row(b_or),
        .frame_done(done_v[1]));

    conv_window_sequencer #(.IMG_W(5), .IMG_H(5), .KERNEL_SIZE(5), .STRIDE(1)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .clear(clear_v[2]), .pix_valid(pix_v[2]),
        .busy(busy_v[2]), .win_valid(win_v[2]), .out_col(c_oc), .out_row(c_or),
        .frame_done(done_v[2]));

    int mw [3] = '{28, 8, 5};
    int mh [3] = '{28, 8, 5};
    int mk [3] = '{5, 3, 5};
    int ms [3] = '{1, 2, 1};

    // Model state: phase 0 idle, 1 run, 2 done; n = pixels accepted this frame.
    int   ph [3];
    int   n  [3];
    logic e_busy [3];
    logic e_win  [3];
    logic e_done [3];
    int   e_oc [3];
    int   e_or [3];

    int vec  = 0;
    int miss = 0;
    int wins [3] = '{0, 0, 0};
    int dones [3] = '{0, 0, 0};
    int last_oc [3];
    int last_or [3];
    int done_win [3];
    int done_oc [3];
    int done_or [3];
    int first_n = -1;

    function automatic bit qualifies(input int w, input int k, input int s, input int idx);
        int c, r;
        c = idx % w;
        r = idx / w;
        return (c >= k - 1) && (r >= k - 1) && ((c - k + 1) % s == 0) && ((r - k + 1) % s == 0);
    endfunction

    // Reference model: which pixel index was accepted decides everything.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                ph[i] <= 0; n[i] <= 0;
                e_busy[i] <= 1'b0; e_win[i] <= 1'b0; e_done[i] <= 1'b0;
                e_oc[i] <= 0; e_or[i] <= 0;
            end else if (clear_v[i]) begin
                ph[i] <= 0; n[i] <= 0;
                e_busy[i] <= 1'b0; e_win[i] <= 1'b0; e_done[i] <= 1'b0;
            end else if (ph[i] == 0) begin
                e_win[i] <= 1'b0; e_done[i] <= 1'b0;
                if (start_v[i]) begin
                    ph[i] <= 1; e_busy[i] <= 1'b1;
                end
            end else if (ph[i] == 1) begin
                e_done[i] <= 1'b0;
                if (pix_v[i]) begin
                    e_win[i] <= qualifies(mw[i], mk[i], ms[i], n[i]);
                    if (qualifies(mw[i], mk[i], ms[i], n[i])) begin
                        e_oc[i] <= ((n[i] % mw[i]) - mk[i] + 1) / ms[i];
                        e_or[i] <= ((n[i] / mw[i]) - mk[i] + 1) / ms[i];
                    end
                    if (n[i] == mw[i] * mh[i] - 1) begin
                        n[i] <= 0; ph[i] <= 2; e_done[i] <= 1'b1; e_busy[i] <= 1'b0;
                    end else begin
                        n[i] <= n[i] + 1;
                    end
                end else begin
                    e_win[i] <= 1'b0;
                end
            end else begin
                ph[i] <= 0; e_win[i] <= 1'b0; e_done[i] <= 1'b0; e_busy[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every instance with the model.
    task automatic tick();
        int doc [3];
        int dor [3];
        @(negedge clk);
        doc = '{int'(a_oc), int'(b_oc), int'(c_oc)};
        dor = '{int'(a_or), int'(b_or), int'(c_or)};
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (busy_v[i] !== e_busy[i] || win_v[i] !== e_win[i] || done_v[i] !== e_done[i]
                || doc[i] != e_oc[i] || dor[i] != e_or[i]) begin
                miss++;
                $display("FAIL cycle inst%0d t=%0t: got busy=%0b win=%0b done=%0b col=%0d row=%0d, want busy=%0b win=%0b done=%0b col=%0d row=%0d",
                         i, $time, busy_v[i], win_v[i], done_v[i], doc[i], dor[i],
                         e_busy[i], e_win[i], e_done[i], e_oc[i], e_or[i]);
            end
            if (win_v[i] === 1'b1) begin
                wins[i]++;
                last_oc[i] = doc[i];
                last_or[i] = dor[i];
                if (i == 0 && first_n < 0) first_n = n[0];
            end
            if (done_v[i] === 1'b1) begin
                dones[i]++;
                done_win[i] = int'(win_v[i]);
                done_oc[i] = doc[i];
                done_or[i] = dor[i];
            end
        end
    endtask

    // Start a frame (with a pixel already presented) and feed it to completion.
    task automatic run_frame(input int i, input bit gaps, input bit poke, output int nwin);
        int d0, w0;
        d0 = dones[i];
        w0 = wins[i];
        start_v[i] = 1'b1;
        pix_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        for (int k = 0; k < 5000 && dones[i] == d0; k++) begin
            pix_v[i] = gaps ? 1'($urandom % 2) : 1'b1;
            start_v[i] = (poke && k == 200) ? 1'b1 : 1'b0;
            tick();
        end
        start_v[i] = 1'b0;
        pix_v[i] = 1'b0;
        chk("frame_done_seen", dones[i] - d0, 1);
        nwin = wins[i] - w0;
        tick();
    endtask

    initial begin
        int nw, d0;
        tick();
        tick();
        chk("reset_busy", int'(busy_v[0]), 0);
        chk("reset_win", int'(win_v[0]), 0);
        chk("reset_done", int'(done_v[0]), 0);
        rst = 1'b0;
        tick();

        // Pixels while idle are ignored.
        pix_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        pix_v[0] = 1'b0;

        // Full frame, pix held high, a stray start mid-frame.
        run_frame(0, 1'b0, 1'b1, nw);
        chk("a_first_win_at_pixel", first_n, 117);
        chk("a_wins", nw, 576);
        chk("a_done_win", done_win[0], 1);
        chk("a_done_col", done_oc[0], 23);
        chk("a_done_row", done_or[0], 23);

        // Frame with random gaps in pix_valid.
        run_frame(0, 1'b1, 1'b0, nw);
        chk("a_gap_wins", nw, 576);

        // Clear after 300 accepted pixels, then a fresh frame.
        d0 = dones[0];
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        pix_v[0] = 1'b1;
        for (int k = 0; k < 1000 && n[0] < 300; k++) tick();
        chk("a_accepted_before_clear", n[0], 300);
        clear_v[0] = 1'b1;
        tick();
        clear_v[0] = 1'b0;
        pix_v[0] = 1'b0;
        chk("a_clear_busy", int'(busy_v[0]), 0);
        tick();
        chk("a_clear_no_done", dones[0] - d0, 0);
        run_frame(0, 1'b0, 1'b0, nw);
        chk("a_after_clear_wins", nw, 576);

        // Reset mid-frame.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        pix_v[0] = 1'b1;
        for (int k = 0; k < 150; k++) tick();
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_win", int'(win_v[0]), 0);
        chk("rst_col", int'(a_oc), 0);
        chk("rst_row", int'(a_or), 0);
        tick();
        rst = 1'b0;
        pix_v[0] = 1'b0;
        tick();

        // 8x8 K3 S2: 3x3 windows, the last pixel never flags.
        run_frame(1, 1'b0, 1'b0, nw);
        chk("b_wins", nw, 9);
        chk("b_last_col", last_oc[1], 2);
        chk("b_last_row", last_or[1], 2);
        chk("b_done_win", done_win[1], 0);

        // Kernel equal to image: one window, on the frame_done cycle.
        run_frame(2, 1'b0, 1'b0, nw);
        chk("c_wins", nw, 1);
        chk("c_done_win", done_win[2], 1);
        chk("c_done_col", done_oc[2], 0);
        chk("c_done_row", done_or[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
